// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  mem_read;
  logic                  mem_write;
  logic [15:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  mem_stall;
  logic                  proto_err;
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, read_valid, mem_stall, proto_err, rd_count, wr_count
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, read_valid, mem_stall, proto_err, rd_count, wr_count
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word-array responder for MEM-stage loads/stores; stalls the
// pipeline for LATENCY cycles per access and reports completion counts.
module data_mem_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input logic               clk,
  input logic               reset_n,
  data_mem_responder_if.slave bus
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic                    proto_err_q, proto_err_d;
  logic [15:0]             rd_count_q, rd_count_d;
  logic [15:0]             wr_count_q, wr_count_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    req;
  logic                    stall;
  logic                    acc_fire;
  logic                    acc_wr;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    mem_we;

  if (ADDR_WIDTH < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[15:ADDR_WIDTH];
  end

  // The array access happens on the edge entering DONE; with LATENCY=1 that
  // edge leaves IDLE directly, so the live request is used instead of the latch.
  always_comb begin
    req         = bus.mem_read | bus.mem_write;
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    proto_err_d = proto_err_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    stall       = 1'b0;
    acc_fire    = 1'b0;
    acc_wr      = op_wr_q;
    acc_addr    = addr_q;
    acc_data    = wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          op_wr_d = bus.mem_write;
          addr_d  = bus.address[ADDR_WIDTH-1:0];
          wdata_d = bus.write_data;
          cnt_d   = CNT_INIT;
          if (bus.mem_read && bus.mem_write) proto_err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d  = DONE;
            acc_fire = 1'b1;
            acc_wr   = bus.mem_write;
            acc_addr = bus.address[ADDR_WIDTH-1:0];
            acc_data = bus.write_data;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = DONE;
          acc_fire = 1'b1;
        end
      end
      DONE: begin
        if (op_wr_q) begin
          if (wr_count_q != '1) wr_count_d = wr_count_q + 16'd1;
        end else begin
          if (rd_count_q != '1) rd_count_d = rd_count_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (acc_fire && !acc_wr) read_data_d = mem_q[acc_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      proto_err_q <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      proto_err_q <= proto_err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Array is deliberately not reset; the reset_n gate drops a store in flight.
  assign mem_we = acc_fire & acc_wr & reset_n;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_addr] <= acc_data;
  end

  assign bus.mem_stall  = stall & reset_n;
  assign bus.read_valid = (state_q == DONE) & ~op_wr_q;
  assign bus.read_data  = read_data_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.rd_count   = rd_count_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances,
// table-driven accesses with a load-data scoreboard plus reset/latency sequences.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if #(.DATA_WIDTH(16)) b0 ();
  data_mem_responder_if #(.DATA_WIDTH(16)) b1 ();

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave)
  );

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          gap;
    logic [15:0] exp_rc;
    logic [15:0] exp_wc;
    bit          exp_perr;
    logic [15:0] exp_hold;
  } vec_t;

  vec_t tbl [10];
  int   vc  [10];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic drive_bus(bit s, bit rd, bit wr, logic [15:0] a, logic [15:0] d);
    if (s) begin
      b1.mem_read = rd; b1.mem_write = wr; b1.address = a; b1.write_data = d;
    end else begin
      b0.mem_read = rd; b0.mem_write = wr; b0.address = a; b0.write_data = d;
    end
  endtask

  function automatic logic g_stall(bit s);  return s ? b1.mem_stall  : b0.mem_stall;  endfunction
  function automatic logic g_valid(bit s);  return s ? b1.read_valid : b0.read_valid; endfunction
  function automatic logic [15:0] g_rdata(bit s); return s ? b1.read_data : b0.read_data; endfunction
  function automatic logic g_perr(bit s);   return s ? b1.proto_err  : b0.proto_err;  endfunction
  function automatic logic [15:0] g_rc(bit s); return s ? b1.rd_count : b0.rd_count; endfunction
  function automatic logic [15:0] g_wc(bit s); return s ? b1.wr_count : b0.wr_count; endfunction

  // One access: drive at a negedge, count stall cycles, check the DONE cycle.
  task automatic access(input bit s, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd, output int vcyc);
    int  n;
    int  lat;
    bit  is_load;
    lat     = s ? 1 : 2;
    is_load = rd && !wr;
    @(negedge clk);
    drive_bus(s, rd, wr, a, d);
    if (is_load) sb_q.push_back(exp_rd);
    #1;
    n = 0;
    while (g_stall(s) && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", n, lat);
    chk("read_valid", {31'd0, g_valid(s)}, {31'd0, is_load});
    vcyc = cyc;
    if (g_valid(s)) begin
      if (sb_q.size() == 0) chk("unexpected_read_valid", 1, 0);
      else chk("read_data", {16'd0, g_rdata(s)}, {16'd0, sb_q.pop_front()});
    end
    drive_bus(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    int v;
    tbl[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1, 16'd0, 16'd1, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1, 16'd1, 16'd1, 1'b0, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b1, 16'h0001, 16'h0011, 16'h0000, 1, 16'd1, 16'd2, 1'b0, 16'hBEEF};
    tbl[3] = '{1'b0, 1'b1, 16'h0002, 16'h0022, 16'h0000, 1, 16'd1, 16'd3, 1'b0, 16'hBEEF};
    tbl[4] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0011, 0, 16'd2, 16'd3, 1'b0, 16'h0011};
    tbl[5] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0022, 1, 16'd3, 16'd3, 1'b0, 16'h0022};
    tbl[6] = '{1'b1, 1'b1, 16'h0007, 16'h1234, 16'h0000, 1, 16'd3, 16'd4, 1'b1, 16'h0022};
    tbl[7] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h1234, 1, 16'd4, 16'd4, 1'b1, 16'h1234};
    tbl[8] = '{1'b0, 1'b1, 16'h0103, 16'hA5A5, 16'h0000, 1, 16'd4, 16'd5, 1'b1, 16'h1234};
    tbl[9] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA5A5, 1, 16'd5, 16'd5, 1'b1, 16'hA5A5};

    drive_bus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_bus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall",  {31'd0, b0.mem_stall},  32'd0);
    chk("rst_valid",  {31'd0, b0.read_valid}, 32'd0);
    chk("rst_rdata",  {16'd0, b0.read_data},  32'd0);
    chk("rst_perr",   {31'd0, b0.proto_err},  32'd0);
    chk("rst_rc",     {16'd0, b0.rd_count},   32'd0);
    chk("rst_wc",     {16'd0, b0.wr_count},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      access(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, v);
      vc[i] = v;
      if (tbl[i].gap > 0) begin
        @(negedge clk);
        #1;
        chk("rd_count",  {16'd0, b0.rd_count},  {16'd0, tbl[i].exp_rc});
        chk("wr_count",  {16'd0, b0.wr_count},  {16'd0, tbl[i].exp_wc});
        chk("proto_err", {31'd0, b0.proto_err}, {31'd0, tbl[i].exp_perr});
        chk("rdata_hold", {16'd0, b0.read_data}, {16'd0, tbl[i].exp_hold});
        chk("idle_valid", {31'd0, b0.read_valid}, 32'd0);
      end
    end
    chk("b2b_spacing", vc[5] - vc[4], 3);

    // Store dropped by a reset pulse during its first BUSY cycle.
    access(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0000, v);
    @(negedge clk);
    drive_bus(1'b0, 1'b0, 1'b1, 16'h0020, 16'h7777);
    @(negedge clk);
    #1;
    chk("busy_stall", {31'd0, b0.mem_stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_stall", {31'd0, b0.mem_stall},  32'd0);
    chk("rstmid_valid", {31'd0, b0.read_valid}, 32'd0);
    chk("rstmid_rc",    {16'd0, b0.rd_count},   32'd0);
    chk("rstmid_wc",    {16'd0, b0.wr_count},   32'd0);
    chk("rstmid_perr",  {31'd0, b0.proto_err},  32'd0);
    chk("rstmid_rdata", {16'd0, b0.read_data},  32'd0);
    drive_bus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, v);
    @(negedge clk);
    #1;
    chk("post_rst_rc", {16'd0, b0.rd_count}, 32'd1);
    chk("post_rst_wc", {16'd0, b0.wr_count}, 32'd0);

    // LATENCY=1 instance: loads issued every other cycle.
    access(1'b1, 1'b0, 1'b1, 16'h0009, 16'h0909, 16'h0000, v);
    access(1'b1, 1'b0, 1'b1, 16'h000A, 16'h0A0A, 16'h0000, v);
    access(1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000, 16'h0909, vc[0]);
    access(1'b1, 1'b1, 1'b0, 16'h000A, 16'h0000, 16'h0A0A, vc[1]);
    access(1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000, 16'h0909, vc[2]);
    chk("lat1_spacing_a", vc[1] - vc[0], 2);
    chk("lat1_spacing_b", vc[2] - vc[1], 2);
    @(negedge clk);
    #1;
    chk("lat1_rc",   {16'd0, b1.rd_count},   32'd3);
    chk("lat1_wc",   {16'd0, b1.wr_count},   32'd2);
    chk("lat1_perr", {31'd0, b1.proto_err},  32'd0);
    chk("lat1_idle_stall", {31'd0, b1.mem_stall}, 32'd0);

    chk("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
